// File: rtl/dyn_seg_capture.sv
// Captures BCD digits from a multiplexed 7-segment drive (COM one-cold, SEG_DEC pattern).
// Optional macro SEG_ALT_GLYPH_EN adds the alternate 6 (7d) and 9 (6f) glyphs.
module dyn_seg_capture #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [6:0]  SEG_DEC,
    input  logic [7:0]  COM,
    output logic [31:0] DIGITS,
    output logic [7:0]  VALID,
    output logic        UPD,
    output logic        SEG_ERR,
    output logic        STALE
);
    localparam int NUM_DIG = 8;
    localparam int TW      = 20;
    localparam logic [7:0]    STB     = 8'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_ONE = TW'(1);

    typedef struct packed {
        logic [7:0] com;
        logic [6:0] seg;
    } pair_t;

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} st_t;

    pair_t                       cur_q, prv_q;
    st_t                         st_q, st_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        acc;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [NUM_DIG-1:0][3:0]     dig_q, dig_d;
    logic [NUM_DIG-1:0]          vld_q, vld_d;
    logic                        stale_q, stale_d, upd_q, upd_d, err_q, err_d;
    logic                        expire;
    logic [7:0]                  sel_n;
    logic                        one_cold, chg;
    logic [2:0]                  sel_idx;
    logic [3:0]                  dec_val;
    logic                        dec_ok;

    assign sel_n    = ~cur_q.com;
    assign one_cold = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
    assign chg      = (cur_q != prv_q);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIG; i++)
            if (sel_n[i]) sel_idx = 3'(i);
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (cur_q.seg)
            7'h3f: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5b: dec_val = 4'd2;
            7'h4f: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6d: dec_val = 4'd5;
            7'h7c: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7f: dec_val = 4'd8;
            7'h67: dec_val = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
            7'h7d: dec_val = 4'd6;
            7'h6f: dec_val = 4'd9;
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        acc   = 1'b0;
        case (st_q)
            WAIT: begin
                if (one_cold) begin
                    st_d  = SETTLE;
                    cnt_d = 8'd1;
                end
            end
            SETTLE: begin
                if (!chg) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (one_cold) begin
                    cnt_d = 8'd1;
                end else begin
                    st_d  = WAIT;
                    cnt_d = 8'd0;
                end
            end
            HELD: begin
                if (chg && one_cold) begin
                    st_d  = SETTLE;
                    cnt_d = 8'd1;
                end else if (chg) begin
                    st_d  = WAIT;
                    cnt_d = 8'd0;
                end
            end
            default: begin
                st_d  = WAIT;
                cnt_d = 8'd0;
            end
        endcase
        // Acceptance fires on the edge the count reaches the threshold, even on a reload to 1.
        if (st_d == SETTLE && cnt_d == STB) begin
            acc  = 1'b1;
            st_d = HELD;
        end
    end

    always_comb begin
        tmo_d   = tmo_q;
        dig_d   = dig_q;
        vld_d   = vld_q;
        stale_d = stale_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        expire  = (tmo_q != TMO_LIM) && ((tmo_q + TMO_ONE) == TMO_LIM);
        if (tmo_q != TMO_LIM) tmo_d = tmo_q + TMO_ONE;
        if (expire) begin
            stale_d = 1'b1;
            vld_d   = '0;
        end
        // Applied after expiry so a same-edge acceptance overrides it.
        if (acc) begin
            if (dec_ok) begin
                dig_d[sel_idx] = dec_val;
                vld_d[sel_idx] = 1'b1;
                upd_d          = 1'b1;
                stale_d        = 1'b0;
                tmo_d          = '0;
            end else begin
                err_d          = 1'b1;
                vld_d[sel_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            cur_q   <= '{com: 8'hff, seg: 7'h00};
            prv_q   <= '{com: 8'hff, seg: 7'h00};
            st_q    <= WAIT;
            cnt_q   <= '0;
            tmo_q   <= '0;
            dig_q   <= '0;
            vld_q   <= '0;
            stale_q <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= '{com: COM, seg: SEG_DEC};
            prv_q   <= cur_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            dig_q   <= dig_d;
            vld_q   <= vld_d;
            stale_q <= stale_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign DIGITS  = dig_q;
    assign VALID   = vld_q;
    assign UPD     = upd_q;
    assign SEG_ERR = err_q;
    assign STALE   = stale_q;
endmodule
